// File: rtl/ram_2rw_1c_be.sv
// ram_2rw_1c_be: single-clock true dual-port RAM with per-lane byte enables,
// selectable same-port read-during-write, an output pipeline with read-valid,
// a write-collision flag and a post-reset clear sequencer.
// Optional feature macro: RFG_RAM_PARITY_EN stores one even-parity bit per lane
// and reports per-lane parity errors alongside read data.
//
// Clear FSM
//   state    | meaning
//   ST_IDLE  | normal operation, port requests accepted
//   ST_CLEAR | zeroing word cnt_q each cycle, all port requests ignored
module ram_2rw_1c_be #(
   parameter int DATASIZE    = 32,
   parameter int ADDRSIZE    = 8,
   parameter int LANESIZE    = 8,
   parameter int OUT_STAGES  = 0,
   parameter int WRITE_FIRST = 0,
   parameter int INIT_RAM    = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   output logic                           init_busy_o,
   input  logic                           wen_a_i,
   input  logic                           ren_a_i,
   input  logic [ADDRSIZE-1:0]            addr_a_i,
   input  logic [DATASIZE/LANESIZE-1:0]   be_a_i,
   input  logic [DATASIZE-1:0]            wdata_a_i,
   output logic [DATASIZE-1:0]            rdata_a_o,
   output logic                           rvalid_a_o,
   output logic [DATASIZE/LANESIZE-1:0]   perr_a_o,
   input  logic                           wen_b_i,
   input  logic                           ren_b_i,
   input  logic [ADDRSIZE-1:0]            addr_b_i,
   input  logic [DATASIZE/LANESIZE-1:0]   be_b_i,
   input  logic [DATASIZE-1:0]            wdata_b_i,
   output logic [DATASIZE-1:0]            rdata_b_o,
   output logic                           rvalid_b_o,
   output logic [DATASIZE/LANESIZE-1:0]   perr_b_o,
   output logic                           collision_o
);

   localparam int NLANES = DATASIZE / LANESIZE;
   localparam int DEPTH  = 1 << ADDRSIZE;
   localparam int NST    = OUT_STAGES + 1;

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t                state_q;
   logic [ADDRSIZE-1:0]   cnt_q;
   logic                  busy_q;
   logic                  coll_q;

   // Port A is index 0, port B is index 1 so both ports share one code path.
   logic                  wen   [2];
   logic                  ren   [2];
   logic [ADDRSIZE-1:0]   addr  [2];
   logic [NLANES-1:0]     be    [2];
   logic [DATASIZE-1:0]   wdata [2];
   logic                  we    [2];
   logic                  re    [2];
   logic                  clr_en;

   logic [DATASIZE-1:0]   mem_q [DEPTH];
   logic [DATASIZE-1:0]   rword [2];

   logic                  pv_q  [2][NST];
   logic [DATASIZE-1:0]   pd_q  [2][NST];

`ifdef RFG_RAM_PARITY_EN
   logic [NLANES-1:0]     par_q [DEPTH];
   logic [NLANES-1:0]     rpar  [2];
   logic [NLANES-1:0]     rerr  [2];
   logic [NLANES-1:0]     pe_q  [2][NST];
`endif

   assign wen[0]   = wen_a_i;
   assign wen[1]   = wen_b_i;
   assign ren[0]   = ren_a_i;
   assign ren[1]   = ren_b_i;
   assign addr[0]  = addr_a_i;
   assign addr[1]  = addr_b_i;
   assign be[0]    = be_a_i;
   assign be[1]    = be_b_i;
   assign wdata[0] = wdata_a_i;
   assign wdata[1] = wdata_b_i;

   // Qualify port requests: nothing is accepted during reset or the clear sequence.
   always_comb begin
      clr_en = (state_q == ST_CLEAR) && !rst_i;
      for (int p = 0; p < 2; p++) begin
         we[p] = wen[p] && !rst_i && !busy_q;
         re[p] = ren[p] && !rst_i && !busy_q;
      end
   end

   // Clear sequencer: one word per cycle after reset, then idle until the next reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= (INIT_RAM != 0) ? ST_CLEAR : ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= (INIT_RAM != 0);
      end else if (state_q == ST_CLEAR) begin
         cnt_q <= cnt_q + 1'b1;
         if (cnt_q == '1) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
         end
      end
   end

   // Storage update: port B is applied first so port A wins lanes both ports enable.
   always_ff @(posedge clk_i) begin
      if (clr_en) begin
         mem_q[cnt_q] <= '0;
`ifdef RFG_RAM_PARITY_EN
         par_q[cnt_q] <= '0;
`endif
      end else begin
         for (int p = 1; p >= 0; p--) begin
            if (we[p]) begin
               for (int l = 0; l < NLANES; l++) begin
                  if (be[p][l]) begin
                     mem_q[addr[p]][l*LANESIZE +: LANESIZE] <= wdata[p][l*LANESIZE +: LANESIZE];
`ifdef RFG_RAM_PARITY_EN
                     par_q[addr[p]][l] <= ^wdata[p][l*LANESIZE +: LANESIZE];
`endif
                  end
               end
            end
         end
      end
   end

   // Read word selection: cross-port always sees pre-write data; the same port
   // optionally sees its own write merged in.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rword[p] = mem_q[addr[p]];
`ifdef RFG_RAM_PARITY_EN
         rpar[p]  = par_q[addr[p]];
`endif
         if ((WRITE_FIRST != 0) && we[p]) begin
            for (int l = 0; l < NLANES; l++) begin
               if (be[p][l]) begin
                  rword[p][l*LANESIZE +: LANESIZE] = wdata[p][l*LANESIZE +: LANESIZE];
`ifdef RFG_RAM_PARITY_EN
                  rpar[p][l] = ^wdata[p][l*LANESIZE +: LANESIZE];
`endif
               end
            end
         end
`ifdef RFG_RAM_PARITY_EN
         rerr[p] = '0;
         for (int l = 0; l < NLANES; l++) begin
            rerr[p][l] = (^rword[p][l*LANESIZE +: LANESIZE]) ^ rpar[p][l];
         end
`endif
      end
   end

   // Read pipeline: each stage only loads when a valid read passes, so the
   // final stage holds the last completed read.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < NST; s++) begin
               pv_q[p][s] <= 1'b0;
               pd_q[p][s] <= '0;
`ifdef RFG_RAM_PARITY_EN
               pe_q[p][s] <= '0;
`endif
            end
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            pv_q[p][0] <= re[p];
            if (re[p]) begin
               pd_q[p][0] <= rword[p];
`ifdef RFG_RAM_PARITY_EN
               pe_q[p][0] <= rerr[p];
`endif
            end
            for (int s = 1; s < NST; s++) begin
               pv_q[p][s] <= pv_q[p][s-1];
               if (pv_q[p][s-1]) begin
                  pd_q[p][s] <= pd_q[p][s-1];
`ifdef RFG_RAM_PARITY_EN
                  pe_q[p][s] <= pe_q[p][s-1];
`endif
               end
            end
         end
      end
   end

   // Collision flag: both ports wrote overlapping lanes of one word last cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         coll_q <= 1'b0;
      end else begin
         coll_q <= we[0] && we[1] && (addr[0] == addr[1]) && ((be[0] & be[1]) != '0);
      end
   end

   assign init_busy_o = busy_q;
   assign collision_o = coll_q;
   assign rdata_a_o   = pd_q[0][NST-1];
   assign rdata_b_o   = pd_q[1][NST-1];
   assign rvalid_a_o  = pv_q[0][NST-1];
   assign rvalid_b_o  = pv_q[1][NST-1];
`ifdef RFG_RAM_PARITY_EN
   assign perr_a_o    = pe_q[0][NST-1];
   assign perr_b_o    = pe_q[1][NST-1];
`else
   assign perr_a_o    = '0;
   assign perr_b_o    = '0;
`endif

endmodule

// File: tb/tb_ram_2rw_1c_be.sv
// Bench for ram_2rw_1c_be: two instances share all inputs, one old-data
// (WRITE_FIRST=0, no extra stages) and one new-data (WRITE_FIRST=1, two extra
// stages). A word/lane reference model predicts every output each cycle.
module tb_ram_2rw_1c_be;

   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int OS0   = 0;
   localparam int OS1   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wen [2];
   logic        ren [2];
   logic [3:0]  addr [2];
   logic [3:0]  be [2];
   logic [31:0] wd [2];

   logic        busy [2];
   logic        coll [2];
   logic [31:0] rd_a [2];
   logic [31:0] rd_b [2];
   logic        rv_a [2];
   logic        rv_b [2];
   logic [3:0]  pe_a [2];
   logic [3:0]  pe_b [2];

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int os [2];

   // reference model
   logic [31:0] mmem [DEPTH];
   logic [3:0]  mbad [DEPTH];
   bit          mbusy;
   int          left;
   bit          ecoll;
   bit          hv [2][2][256];
   logic [31:0] hd [2][2][256];
   logic [3:0]  hp [2][2][256];
   logic [31:0] exp_rd [2][2];

   always #5 clk = ~clk;

   ram_2rw_1c_be #(.DATASIZE(32), .ADDRSIZE(AW), .LANESIZE(8), .OUT_STAGES(OS0),
                   .WRITE_FIRST(0), .INIT_RAM(1)) u_wf0 (
      .clk_i(clk), .rst_i(rst), .init_busy_o(busy[0]),
      .wen_a_i(wen[0]), .ren_a_i(ren[0]), .addr_a_i(addr[0]), .be_a_i(be[0]), .wdata_a_i(wd[0]),
      .rdata_a_o(rd_a[0]), .rvalid_a_o(rv_a[0]), .perr_a_o(pe_a[0]),
      .wen_b_i(wen[1]), .ren_b_i(ren[1]), .addr_b_i(addr[1]), .be_b_i(be[1]), .wdata_b_i(wd[1]),
      .rdata_b_o(rd_b[0]), .rvalid_b_o(rv_b[0]), .perr_b_o(pe_b[0]),
      .collision_o(coll[0]));

   ram_2rw_1c_be #(.DATASIZE(32), .ADDRSIZE(AW), .LANESIZE(8), .OUT_STAGES(OS1),
                   .WRITE_FIRST(1), .INIT_RAM(1)) u_wf1 (
      .clk_i(clk), .rst_i(rst), .init_busy_o(busy[1]),
      .wen_a_i(wen[0]), .ren_a_i(ren[0]), .addr_a_i(addr[0]), .be_a_i(be[0]), .wdata_a_i(wd[0]),
      .rdata_a_o(rd_a[1]), .rvalid_a_o(rv_a[1]), .perr_a_o(pe_a[1]),
      .wen_b_i(wen[1]), .ren_b_i(ren[1]), .addr_b_i(addr[1]), .be_b_i(be[1]), .wdata_b_i(wd[1]),
      .rdata_b_o(rd_b[1]), .rvalid_b_o(rv_b[1]), .perr_b_o(pe_b[1]),
      .collision_o(coll[1]));

   task automatic idle();
      for (int p = 0; p < 2; p++) begin
         wen[p] = 1'b0; ren[p] = 1'b0; addr[p] = '0; be[p] = '0; wd[p] = '0;
      end
   endtask

   task automatic rand_req(input int amax);
      for (int p = 0; p < 2; p++) begin
         wen[p]  = 1'($urandom_range(0, 1));
         ren[p]  = 1'($urandom_range(0, 1));
         addr[p] = 4'($urandom_range(0, amax));
         be[p]   = 4'($urandom);
         wd[p]   = $urandom;
      end
   endtask

   // One clock: predict, advance, then compare every output of both instances.
   task automatic cycle();
      int          n;
      int          idx;
      logic [31:0] w;
      logic [3:0]  b;
      logic        rv;
      logic [31:0] rdat;
      logic [3:0]  pe;
      n = (cyc + 1) % 256;
      for (int i = 0; i < 2; i++) begin
         for (int p = 0; p < 2; p++) begin
            hv[i][p][n] = 1'b0;
            if (!rst && !mbusy && ren[p]) begin
               w = mmem[addr[p]];
               b = mbad[addr[p]];
               if (i == 1 && wen[p]) begin
                  for (int l = 0; l < 4; l++) begin
                     if (be[p][l]) begin
                        w[l*8 +: 8] = wd[p][l*8 +: 8];
                        b[l] = 1'b0;
                     end
                  end
               end
               hv[i][p][n] = 1'b1;
               hd[i][p][n] = w;
               hp[i][p][n] = b;
            end
         end
      end
      ecoll = !rst && !mbusy && wen[0] && wen[1] && (addr[0] == addr[1]) && ((be[0] & be[1]) != 4'h0);
      if (rst) begin
         mbusy = 1'b1;
         left  = DEPTH;
         for (int a = 0; a < DEPTH; a++) begin
            mmem[a] = '0;
            mbad[a] = '0;
         end
         for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
               exp_rd[i][p] = '0;
               for (int k = 0; k < 256; k++) hv[i][p][k] = 1'b0;
            end
         end
      end else if (mbusy) begin
         left--;
         if (left == 0) mbusy = 1'b0;
      end else begin
         for (int p = 1; p >= 0; p--) begin
            if (wen[p]) begin
               for (int l = 0; l < 4; l++) begin
                  if (be[p][l]) begin
                     mmem[addr[p]][l*8 +: 8] = wd[p][l*8 +: 8];
                     mbad[addr[p]][l] = 1'b0;
                  end
               end
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (busy[i] !== mbusy) begin
            n_err++;
            $display("FAIL init_busy inst%0d cyc%0d: got %b expected %b", i, cyc, busy[i], mbusy);
         end
         n_cmp++;
         if (coll[i] !== ecoll) begin
            n_err++;
            $display("FAIL collision inst%0d cyc%0d: got %b expected %b", i, cyc, coll[i], ecoll);
         end
         for (int p = 0; p < 2; p++) begin
            idx = cyc - os[i];
            rv  = (idx >= 0) ? hv[i][p][idx % 256] : 1'b0;
            if (rv) exp_rd[i][p] = hd[i][p][idx % 256];
            rdat = (p == 0) ? rd_a[i] : rd_b[i];
            pe   = (p == 0) ? pe_a[i] : pe_b[i];
            n_cmp++;
            if (((p == 0) ? rv_a[i] : rv_b[i]) !== rv) begin
               n_err++;
               $display("FAIL rvalid inst%0d port%0d cyc%0d: got %b expected %b", i, p, cyc,
                        (p == 0) ? rv_a[i] : rv_b[i], rv);
            end
            n_cmp++;
            if (rdat !== exp_rd[i][p]) begin
               n_err++;
               $display("FAIL rdata inst%0d port%0d cyc%0d: got %h expected %h", i, p, cyc,
                        rdat, exp_rd[i][p]);
            end
            if (rv) begin
               n_cmp++;
               if (pe !== hp[i][p][idx % 256]) begin
                  n_err++;
                  $display("FAIL perr inst%0d port%0d cyc%0d: got %b expected %b", i, p, cyc,
                           pe, hp[i][p][idx % 256]);
               end
            end
         end
      end
   endtask

   task automatic wait_clear_and_count(input string tag);
      int k;
      k = 0;
      while (busy[0] === 1'b1 && k < 40) begin
         rand_req(15);
         cycle();
         k++;
      end
      idle();
      n_cmp++;
      if (k != DEPTH - 1) begin
         n_err++;
         $display("FAIL %s busy_cycles: got %0d expected %0d", tag, k + 1, DEPTH);
      end
   endtask

   task automatic read_all();
      for (int a = 0; a < DEPTH; a++) begin
         idle();
         ren[0] = 1'b1; addr[0] = 4'(a);
         ren[1] = 1'b1; addr[1] = 4'(DEPTH - 1 - a);
         cycle();
      end
      idle();
      repeat (3) cycle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rand_req(15);
      cycle();
      cycle();
      rst = 1'b0;
      // first post-reset cycle is busy with clear word 0
      rand_req(15);
      cycle();
      wait_clear_and_count("reset");
      read_all();
   endtask

   task automatic test_lane_write();
      idle(); wen[0] = 1'b1; addr[0] = 4'd3; be[0] = 4'hF; wd[0] = 32'hFFFFFFFF;
      cycle();
      idle(); wen[0] = 1'b1; addr[0] = 4'd3; be[0] = 4'b0101; wd[0] = 32'h11223344;
      cycle();
      idle(); wen[0] = 1'b1; addr[0] = 4'd3; be[0] = 4'b0000; wd[0] = 32'h0;
      cycle();
      idle(); ren[0] = 1'b1; addr[0] = 4'd3;
      cycle();
      n_cmp++;
      if (rd_a[0] !== 32'hFF22FF44) begin
         n_err++;
         $display("FAIL lane_write inst0: got %h expected %h", rd_a[0], 32'hFF22FF44);
      end
      idle();
      cycle(); cycle();
      n_cmp++;
      if (rd_a[1] !== 32'hFF22FF44 || rv_a[1] !== 1'b1) begin
         n_err++;
         $display("FAIL lane_write inst1: got %h/%b expected %h/1", rd_a[1], rv_a[1], 32'hFF22FF44);
      end
      cycle();
   endtask

   task automatic test_collision();
      idle(); wen[0] = 1'b1; addr[0] = 4'd5; be[0] = 4'hF; wd[0] = 32'h12345678;
      cycle();
      idle();
      wen[0] = 1'b1; addr[0] = 4'd5; be[0] = 4'b0011; wd[0] = 32'hAAAAAAAA;
      wen[1] = 1'b1; addr[1] = 4'd5; be[1] = 4'b0110; wd[1] = 32'hBBBBBBBB;
      cycle();
      n_cmp++;
      if (coll[0] !== 1'b1) begin
         n_err++;
         $display("FAIL collision_pulse: got %b expected 1", coll[0]);
      end
      idle(); ren[1] = 1'b1; addr[1] = 4'd5;
      cycle();
      n_cmp++;
      if (coll[0] !== 1'b0 || rd_b[0] !== 32'h12BBAAAA) begin
         n_err++;
         $display("FAIL collision_merge: got coll=%b data=%h expected coll=0 data=%h",
                  coll[0], rd_b[0], 32'h12BBAAAA);
      end
      // same address, disjoint lanes: no collision
      idle();
      wen[0] = 1'b1; addr[0] = 4'd6; be[0] = 4'b0001; wd[0] = $urandom;
      wen[1] = 1'b1; addr[1] = 4'd6; be[1] = 4'b1000; wd[1] = $urandom;
      cycle();
      idle();
      repeat (3) cycle();
   endtask

   task automatic test_rdw();
      idle(); wen[1] = 1'b1; addr[1] = 4'd7; be[1] = 4'hF; wd[1] = 32'h9;
      cycle();
      idle();
      wen[0] = 1'b1; ren[0] = 1'b1; addr[0] = 4'd7; be[0] = 4'hF; wd[0] = 32'h5;
      ren[1] = 1'b1; addr[1] = 4'd7;
      cycle();
      n_cmp++;
      if (rd_a[0] !== 32'h9 || rd_b[0] !== 32'h9) begin
         n_err++;
         $display("FAIL rdw_old: got A=%h B=%h expected A=9 B=9", rd_a[0], rd_b[0]);
      end
      idle();
      cycle(); cycle();
      n_cmp++;
      if (rd_a[1] !== 32'h5 || rd_b[1] !== 32'h9) begin
         n_err++;
         $display("FAIL rdw_new: got A=%h B=%h expected A=5 B=9", rd_a[1], rd_b[1]);
      end
      cycle();
   endtask

   task automatic test_reset_mid_clear();
      rst = 1'b1; idle();
      cycle();
      rst = 1'b0;
      repeat (6) begin
         rand_req(15);
         cycle();
      end
      rst = 1'b1; rand_req(15);
      cycle();
      rst = 1'b0;
      rand_req(15);
      cycle();
      wait_clear_and_count("mid_clear");
      read_all();
   endtask

   task automatic test_back_to_back();
      int cnt;
      for (int a = 0; a < DEPTH; a += 2) begin
         idle();
         wen[0] = 1'b1; addr[0] = 4'(a);     be[0] = 4'hF; wd[0] = $urandom;
         wen[1] = 1'b1; addr[1] = 4'(a + 1); be[1] = 4'hF; wd[1] = $urandom;
         cycle();
      end
      cnt = 0;
      for (int a = 0; a < DEPTH + 3; a++) begin
         idle();
         if (a < DEPTH) begin
            ren[0] = 1'b1; addr[0] = 4'(a);
            ren[1] = 1'b1; addr[1] = 4'(a ^ 5);
         end
         cycle();
         if (rv_a[1] === 1'b1) cnt++;
      end
      n_cmp++;
      if (cnt != DEPTH) begin
         n_err++;
         $display("FAIL back_to_back_count: got %0d expected %0d", cnt, DEPTH);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         rand_req((k < 300) ? 3 : 15);
         cycle();
      end
      idle();
      repeat (3) cycle();
   endtask

`ifdef RFG_RAM_PARITY_EN
   task automatic test_parity();
      idle(); wen[0] = 1'b1; addr[0] = 4'd9; be[0] = 4'hF; wd[0] = 32'hC3A55A3C;
      cycle();
      idle();
      u_wf0.mem_q[9] = u_wf0.mem_q[9] ^ 32'h0001_0000;
      u_wf1.mem_q[9] = u_wf1.mem_q[9] ^ 32'h0001_0000;
      mmem[9] = mmem[9] ^ 32'h0001_0000;
      mbad[9] = 4'b0100;
      ren[0] = 1'b1; addr[0] = 4'd9;
      cycle();
      n_cmp++;
      if (pe_a[0] !== 4'b0100 || rv_a[0] !== 1'b1) begin
         n_err++;
         $display("FAIL parity_flip: got perr=%b rvalid=%b expected 0100/1", pe_a[0], rv_a[0]);
      end
      idle();
      repeat (3) cycle();
   endtask
`endif

   initial begin
      os[0] = OS0;
      os[1] = OS1;
      mbusy = 1'b0;
      left  = 0;
      idle();
      test_reset();
      test_lane_write();
      test_collision();
      test_rdw();
      test_back_to_back();
`ifdef RFG_RAM_PARITY_EN
      test_parity();
`endif
      test_random();
      test_reset_mid_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
